seq_div_32: RTL and testbench

Multi-cycle shift-subtract (restoring) integer divider for the ALU's DIV path, built on the same add/subtract datapath style as the ripple-carry adder/subtractor. It accepts a dividend/divisor pair on a start pulse, produces one quotient bit per clock, and returns quotient and remainder with a one-cycle done strobe. The ALU control FSM stalls on BUSY while the divide is in flight.

---
 rtl/seq_div_32.sv | 163 ++++++++++++++++
 tb/tb_seq_div_32.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_div_32.sv
// Multi-cycle restoring divider: one quotient bit per clock, registered results with a DONE strobe.
// Optional two's-complement operation is built when SEQ_DIV_SIGNED_EN is defined.
module seq_div_32 #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] DIVIDEND,
    input  logic [WIDTH-1:0] DIVISOR,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] QUOTIENT,
    output logic [WIDTH-1:0] REMAINDER,
    output logic             DIV_BY_ZERO,
    output logic [1:0]       DBG_STATE
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   prem_q, prem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dz_q, dz_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] dvd_load;
    logic [WIDTH-1:0] dvs_load;
    logic [WIDTH-1:0] quot_fix;
    logic [WIDTH-1:0] rem_fix;

    // Partial remainder always stays below the divisor, so its top bit is zero before the shift.
    assign shifted = {prem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvs_q};

`ifdef SEQ_DIV_SIGNED_EN
    logic qneg_q, qneg_d;
    logic rneg_q, rneg_d;

    // A zero divisor keeps the raw dividend so it can be returned unchanged as the remainder.
    assign dvd_load = (DIVIDEND[WIDTH-1] && (DIVISOR != '0)) ? ('0 - DIVIDEND) : DIVIDEND;
    assign dvs_load = DIVISOR[WIDTH-1] ? ('0 - DIVISOR) : DIVISOR;
    assign quot_fix = qneg_q ? ('0 - dvd_q) : dvd_q;
    assign rem_fix  = rneg_q ? ('0 - prem_q[WIDTH-1:0]) : prem_q[WIDTH-1:0];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
        end else begin
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
        end
    end

    always_comb begin
        qneg_d = qneg_q;
        rneg_d = rneg_q;
        if (state_q == S_IDLE && START) begin
            qneg_d = DIVIDEND[WIDTH-1] ^ DIVISOR[WIDTH-1];
            rneg_d = DIVIDEND[WIDTH-1];
        end
    end
`else
    assign dvd_load = DIVIDEND;
    assign dvs_load = DIVISOR;
    assign quot_fix = dvd_q;
    assign rem_fix  = prem_q[WIDTH-1:0];
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            prem_q  <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prem_q  <= prem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prem_d  = prem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    dvd_d   = dvd_load;
                    dvs_d   = dvs_load;
                    prem_d  = '0;
                    cnt_d   = '0;
                    state_d = (DIVISOR == '0) ? S_FINISH : S_RUN;
                end
            end
            S_RUN: begin
                // dvd_q shifts left, collecting quotient bits in its LSB as the dividend drains out.
                if (!diff[WIDTH]) begin
                    prem_d = diff;
                    dvd_d  = {dvd_q[WIDTH-2:0], 1'b1};
                end else begin
                    prem_d = shifted;
                    dvd_d  = {dvd_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                if (dvs_q == '0) begin
                    quot_d = '1;
                    rem_d  = dvd_q;
                    dz_d   = 1'b1;
                end else begin
                    quot_d = quot_fix;
                    rem_d  = rem_fix;
                    dz_d   = 1'b0;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign BUSY        = (state_q != S_IDLE);
    assign DONE        = done_q;
    assign QUOTIENT    = quot_q;
    assign REMAINDER   = rem_q;
    assign DIV_BY_ZERO = dz_q;
    assign DBG_STATE   = state_q;
endmodule

// File: tb/tb_seq_div_32.sv
// Directed self-checking bench for seq_div_32: latency, results, divide-by-zero, ignored START, reset abort.
module tb_seq_div_32;
  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int lat;
  int busy_bad;
  int done_seen;

  seq_div_32 #(.WIDTH(32)) dut (
    .CLK(clk), .RST(rst), .START(start), .DIVIDEND(dividend), .DIVISOR(divisor),
    .BUSY(busy), .DONE(done), .QUOTIENT(quotient), .REMAINDER(remainder),
    .DIV_BY_ZERO(div_by_zero), .DBG_STATE(dbg_state)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one START pulse; returns 1ns after the accepting edge.
  task automatic start_div(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count edges until DONE, flagging any cycle where BUSY drops early; -1 on timeout.
  task automatic wait_done(output int n);
    n = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        n = i;
        break;
      end
      if (!busy) busy_bad++;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    busy_bad = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_q", quotient, 0);
    check("reset_r", remainder, 0);
    check("reset_dz", div_by_zero, 0);
    check("reset_state", dbg_state, 0);
    @(negedge clk);
    rst = 1'b0;

    // 100 / 7
    start_div(32'd100, 32'd7);
    check("accept_busy", busy, 1);
    check("accept_state_run", dbg_state, 1);
    wait_done(lat);
    check("lat_100_7", lat, 33);
    check("busy_held_100_7", busy_bad, 0);
    check("busy_low_at_done", busy, 0);
    check("q_100_7", quotient, 14);
    check("r_100_7", remainder, 2);
    check("dz_100_7", div_by_zero, 0);
    @(posedge clk); #1;
    check("done_one_cycle", done, 0);
    check("q_hold", quotient, 14);

    // all-ones / 1
    start_div(32'hFFFF_FFFF, 32'd1);
    wait_done(lat);
    check("lat_max_1", lat, 33);
    check("q_max_1", quotient, 32'hFFFF_FFFF);
    check("r_max_1", remainder, 0);

    // 5 / all-ones
    start_div(32'd5, 32'hFFFF_FFFF);
    wait_done(lat);
`ifdef SEQ_DIV_SIGNED_EN
    check("q_5_m1", quotient, 32'hFFFF_FFFB);
    check("r_5_m1", remainder, 0);
`else
    check("q_5_max", quotient, 0);
    check("r_5_max", remainder, 5);
`endif

    // small / large
    start_div(32'd7, 32'd100);
    wait_done(lat);
    check("q_7_100", quotient, 0);
    check("r_7_100", remainder, 7);

    // divide by zero
    start_div(32'd1234, 32'd0);
    check("dz_accept_state", dbg_state, 2);
    wait_done(lat);
    check("lat_dz", lat, 1);
    check("dz_flag", div_by_zero, 1);
    check("q_dz", quotient, 32'hFFFF_FFFF);
    check("r_dz", remainder, 1234);
    check("busy_low_dz", busy, 0);

    // START during BUSY is ignored, then back-to-back START right after DONE
    busy_bad = 0;
    start_div(32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    dividend = 32'd9; divisor = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat);
    check("lat_ignored_start", lat + 10, 33);
    check("q_ignored_start", quotient, 14);
    check("r_ignored_start", remainder, 2);
    check("dz_clear_after_dz", div_by_zero, 0);
    dividend = 32'd9; divisor = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_done_low", done, 0);
    check("b2b_busy", busy, 1);
    wait_done(lat);
    check("lat_b2b", lat, 33);
    check("q_9_3", quotient, 3);
    check("r_9_3", remainder, 0);
    check("busy_held_seq", busy_bad, 0);

    // reset mid-operation
    start_div(32'd100, 32'd7);
    repeat (14) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_q", quotient, 0);
    check("midrst_r", remainder, 0);
    check("midrst_dz", div_by_zero, 0);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done || busy) done_seen++;
    end
    check("no_done_after_rst", done_seen, 0);
    busy_bad = 0;
    start_div(32'd1000, 32'd10);
    wait_done(lat);
    check("lat_after_rst", lat, 33);
    check("q_after_rst", quotient, 100);
    check("r_after_rst", remainder, 0);

`ifdef SEQ_DIV_SIGNED_EN
    start_div(32'hFFFF_FFF9, 32'd2);
    wait_done(lat);
    check("q_m7_2", quotient, 32'hFFFF_FFFD);
    check("r_m7_2", remainder, 32'hFFFF_FFFF);
    start_div(32'd7, 32'hFFFF_FFFE);
    wait_done(lat);
    check("q_7_m2", quotient, 32'hFFFF_FFFD);
    check("r_7_m2", remainder, 1);
    start_div(32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(lat);
    check("q_ovf", quotient, 32'h8000_0000);
    check("r_ovf", remainder, 0);
    check("dz_ovf", div_by_zero, 0);
    start_div(32'hFFFF_FFF8, 32'd0);
    wait_done(lat);
    check("q_sdz", quotient, 32'hFFFF_FFFF);
    check("r_sdz", remainder, 32'hFFFF_FFF8);
    check("dz_sdz", div_by_zero, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
